// File: rtl/slc3_mem_ctrl_if.sv
// Purpose: bundles the SLC-3 core request/response lines and the block RAM port seen by slc3_mem_ctrl.
// Latency: wiring only, no storage.
// Backpressure: none on the bus itself; the core holds its request level and waits for the R pulse.
//
// Ports (slave = controller view):
//   ADDR, Data_to_SRAM, OE, WE  core request (in)
//   Data_from_SRAM, R, busy     core response (out)
//   mem_en, mem_we, mem_addr, mem_din  block RAM command (out)
//   mem_dout                    block RAM read data (in)
interface slc3_mem_ctrl_if;
    logic [15:0] ADDR;
    logic [15:0] Data_to_SRAM;
    logic        OE;
    logic        WE;
    logic [15:0] Data_from_SRAM;
    logic        R;
    logic        busy;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_din;
    logic [15:0] mem_dout;

    modport slave (
        input  ADDR, Data_to_SRAM, OE, WE, mem_dout,
        output Data_from_SRAM, R, busy, mem_en, mem_we, mem_addr, mem_din
    );

    modport master (
        output ADDR, Data_to_SRAM, OE, WE, mem_dout,
        input  Data_from_SRAM, R, busy, mem_en, mem_we, mem_addr, mem_din
    );
endinterface

// File: rtl/slc3_mem_ctrl.sv
// Purpose: turns the SLC-3 core's level OE/WE requests into single-cycle block RAM accesses and returns R.
// Latency: write 2 cycles, read RD_LAT+2 cycles from the sampling edge to the R pulse.
// Backpressure: a new request is only sampled in IDLE; a request still held after R parks in HOLD until OE=WE=0.
//
// Ports: Clk (rising edge), Reset (async, active-low), bus (slc3_mem_ctrl_if.slave: core request/response
// plus block RAM command and read data). RD_LAT is the block RAM read latency, legal range 1..7.
module slc3_mem_ctrl #(
    parameter int unsigned RD_LAT = 2
) (
    input  logic           Clk,
    input  logic           Reset,
    slc3_mem_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_WAIT,
        RD_DONE,
        WR_ISSUE,
        WR_DONE,
        HOLD
    } state_t;

    // RD_WAIT is left on the cycle the counter reads 0, so loading RD_LAT-1
    // places the capture exactly on the cycle mem_dout becomes valid.
    localparam logic [2:0] WAIT_LOAD = 3'(RD_LAT - 1);

    state_t      state_q;
    logic [2:0]  wait_cnt_q;
    logic [15:0] rd_data_q;
    logic [15:0] mem_addr_q;
    logic [15:0] mem_din_q;
    logic        r_q;
    logic        busy_q;
    logic        mem_en_q;
    logic        mem_we_q;

    // Outputs are registered alongside the state: each one is set on the edge
    // that enters the state in which it must be visible.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q    <= IDLE;
            wait_cnt_q <= 3'd0;
            rd_data_q  <= 16'h0000;
            mem_addr_q <= 16'h0000;
            mem_din_q  <= 16'h0000;
            r_q        <= 1'b0;
            busy_q     <= 1'b0;
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
        end else begin
            // Single-cycle pulses default low.
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
            r_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    // Write has priority when both request levels are high.
                    if (bus.WE) begin
                        mem_addr_q <= bus.ADDR;
                        mem_din_q  <= bus.Data_to_SRAM;
                        mem_en_q   <= 1'b1;
                        mem_we_q   <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= WR_ISSUE;
                    end else if (bus.OE) begin
                        mem_addr_q <= bus.ADDR;
                        mem_en_q   <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= RD_ISSUE;
                    end
                end
                WR_ISSUE: begin
                    r_q     <= 1'b1;
                    state_q <= WR_DONE;
                end
                WR_DONE: begin
                    state_q <= HOLD;
                end
                RD_ISSUE: begin
                    wait_cnt_q <= WAIT_LOAD;
                    state_q    <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (wait_cnt_q == 3'd0) begin
                        rd_data_q <= bus.mem_dout;
                        r_q       <= 1'b1;
                        state_q   <= RD_DONE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 3'd1;
                    end
                end
                RD_DONE: begin
                    state_q <= HOLD;
                end
                HOLD: begin
                    // Wait for the core to drop its request so it cannot re-issue.
                    if (!bus.OE && !bus.WE) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.Data_from_SRAM = rd_data_q;
    assign bus.R              = r_q;
    assign bus.busy           = busy_q;
    assign bus.mem_en         = mem_en_q;
    assign bus.mem_we         = mem_we_q;
    assign bus.mem_addr       = mem_addr_q;
    assign bus.mem_din        = mem_din_q;
endmodule

// File: tb/tb_slc3_mem_ctrl.sv
// Purpose: checks slc3_mem_ctrl at RD_LAT 1, 2 and 7 against a transaction-level model, directed and random.
// Latency: n/a (bench).
// Backpressure: n/a (bench drives the core request levels directly).
module tb_slc3_mem_ctrl;
    logic        clk        = 1'b0;
    logic        rst_n      = 1'b1;
    logic [15:0] core_addr  = 16'h0000;
    logic [15:0] core_wdata = 16'h0000;
    logic        core_oe    = 1'b0;
    logic        core_we    = 1'b0;
    int          cyc        = 0;
    int          tests      = 0;
    int          fails      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Per-instance observations exported from the generate blocks.
    int          r_cyc_a  [3];
    int          r_cnt_a  [3];
    int          en_cnt_a [3];
    int          we_cnt_a [3];
    logic [15:0] dout_a   [3];
    logic [15:0] maddr_a  [3];
    logic        busy_a   [3];
    logic [51:0] obs_a    [3];

    // Power-on contents of the RAM; address 3 holds the pre-loaded 16'h1234.
    function automatic logic [15:0] init_val(logic [15:0] a);
        if (a == 16'h0003) return 16'h1234;
        return (a * 16'h9E37) ^ 16'h5A5A;
    endfunction

    function automatic int lat_of(int k);
        return (k == 0) ? 1 : ((k == 1) ? 2 : 7);
    endfunction

    task automatic chk(string nm, int k, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s inst%0d cyc%0d: got %0h expected %0h", nm, k, cyc, act, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int L = (g == 0) ? 1 : ((g == 1) ? 2 : 7);

        slc3_mem_ctrl_if bus ();
        logic [15:0] ram [0:65535];
        logic [15:0] dly [1:7];
        logic [15:0] mm  [0:65535];
        int r_cyc  = -100;
        int r_cnt  = 0;
        int en_cnt = 0;
        int we_cnt = 0;

        assign bus.ADDR         = core_addr;
        assign bus.Data_to_SRAM = core_wdata;
        assign bus.OE           = core_oe;
        assign bus.WE           = core_we;
        assign bus.mem_dout     = dly[L];

        slc3_mem_ctrl #(.RD_LAT(L)) u_dut (
            .Clk   (clk),
            .Reset (rst_n),
            .bus   (bus)
        );

        assign r_cyc_a[g]  = r_cyc;
        assign r_cnt_a[g]  = r_cnt;
        assign en_cnt_a[g] = en_cnt;
        assign we_cnt_a[g] = we_cnt;
        assign dout_a[g]   = bus.Data_from_SRAM;
        assign maddr_a[g]  = bus.mem_addr;
        assign busy_a[g]   = bus.busy;
        assign obs_a[g]    = {bus.R, bus.busy, bus.mem_en, bus.mem_we,
                              bus.mem_addr, bus.mem_din, bus.Data_from_SRAM};

        // Block RAM: data valid L cycles after the enable cycle, garbage otherwise.
        initial begin : ram_model
            for (int a = 0; a < 65536; a++) ram[a] = init_val(16'(a));
            for (int k = 1; k <= 7; k++) dly[k] <= 16'hDEAD;
            forever begin
                @(posedge clk);
                dly[1] <= (bus.mem_en && !bus.mem_we) ? ram[bus.mem_addr] : 16'hDEAD;
                for (int k = 2; k <= 7; k++) dly[k] <= dly[k-1];
                if (bus.mem_en && bus.mem_we) ram[bus.mem_addr] = bus.mem_din;
            end
        end

        // Transaction model: an access sampled at cycle s has its enable at s+1,
        // R at s+lat, busy from s+1 until the hold-release cycle.
        initial begin : ref_model
            bit          active;
            bit          is_wr;
            bit          idle;
            bit          e_en;
            bit          e_we;
            bit          e_r;
            bit          e_busy;
            int          s;
            int          lat;
            int          rel;
            int          c;
            int          n;
            logic [15:0] a_addr;
            logic [15:0] a_data;
            logic [15:0] pend;
            logic [15:0] e_dout;
            logic [15:0] e_addr;
            logic [15:0] e_din;
            active = 1'b0; is_wr = 1'b0; s = 0; lat = 0; rel = -1;
            a_addr = 16'h0; a_data = 16'h0; pend = 16'h0;
            e_dout = 16'h0; e_addr = 16'h0; e_din = 16'h0;
            for (int a = 0; a < 65536; a++) mm[a] = init_val(16'(a));
            forever begin
                @(posedge clk);
                c = cyc;
                if (!rst_n) begin
                    active = 1'b0; rel = -1;
                    e_dout = 16'h0; e_addr = 16'h0; e_din = 16'h0;
                end else begin
                    if (active && is_wr && c == s + 1) mm[a_addr] = a_data;
                    idle = !active || (rel >= 0 && c > rel);
                    if (idle && (core_we || core_oe)) begin
                        active = 1'b1;
                        s      = c;
                        is_wr  = core_we;
                        a_addr = core_addr;
                        a_data = core_wdata;
                        lat    = is_wr ? 2 : L + 2;
                        rel    = -1;
                        pend   = mm[core_addr];
                        e_addr = core_addr;
                        if (is_wr) e_din = core_wdata;
                    end else if (active && rel < 0 && c >= s + lat + 1 && !core_we && !core_oe) begin
                        rel = c;
                    end
                end
                #1;
                n      = cyc;
                e_en   = active && (n == s + 1);
                e_we   = e_en && is_wr;
                e_r    = active && (n == s + lat);
                e_busy = active && (n >= s + 1) && (rel < 0 || n <= rel);
                if (active && !is_wr && n == s + lat) e_dout = pend;
                chk("mem_en",   g, 64'(bus.mem_en),         64'(e_en));
                chk("mem_we",   g, 64'(bus.mem_we),         64'(e_we));
                chk("R",        g, 64'(bus.R),              64'(e_r));
                chk("busy",     g, 64'(bus.busy),           64'(e_busy));
                chk("mem_addr", g, 64'(bus.mem_addr),       64'(e_addr));
                chk("mem_din",  g, 64'(bus.mem_din),        64'(e_din));
                chk("dout",     g, 64'(bus.Data_from_SRAM), 64'(e_dout));
                if (bus.R) begin
                    r_cyc = n;
                    r_cnt++;
                end
                if (bus.mem_en) en_cnt++;
                if (bus.mem_we) we_cnt++;
            end
        end
    end

    int smp;
    int b_en [3];
    int b_we [3];
    int b_r  [3];

    task automatic drive(bit we, bit oe, logic [15:0] a, logic [15:0] d);
        @(negedge clk);
        core_we    = we;
        core_oe    = oe;
        core_addr  = a;
        core_wdata = d;
    endtask

    task automatic gap(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic snap();
        for (int k = 0; k < 3; k++) begin
            b_en[k] = en_cnt_a[k];
            b_we[k] = we_cnt_a[k];
            b_r[k]  = r_cnt_a[k];
        end
    endtask

    initial begin
        #1 rst_n = 1'b0;
        gap(3);
        for (int k = 0; k < 3; k++) chk("reset_outputs", k, 64'(obs_a[k]), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        gap(2);

        // Write 16'hBEEF to 16'h0010, then read it back.
        drive(1'b1, 1'b0, 16'h0010, 16'hBEEF);
        smp = cyc;
        snap();
        drive(1'b0, 1'b0, 16'h0010, 16'h0000);
        gap(12);
        for (int k = 0; k < 3; k++) begin
            chk("wr_latency", k, 64'(r_cyc_a[k] - smp), 64'd2);
            chk("wr_en_count", k, 64'(en_cnt_a[k] - b_en[k]), 64'd1);
            chk("wr_we_count", k, 64'(we_cnt_a[k] - b_we[k]), 64'd1);
        end
        drive(1'b0, 1'b1, 16'h0010, 16'h0000);
        smp = cyc;
        snap();
        drive(1'b0, 1'b0, 16'h0010, 16'h0000);
        gap(14);
        for (int k = 0; k < 3; k++) begin
            chk("rd_latency", k, 64'(r_cyc_a[k] - smp), 64'(lat_of(k) + 2));
            chk("rd_beef", k, 64'(dout_a[k]), 64'hBEEF);
            chk("rd_en_count", k, 64'(en_cnt_a[k] - b_en[k]), 64'd1);
            chk("rd_we_count", k, 64'(we_cnt_a[k] - b_we[k]), 64'd0);
        end

        // Latency sweep on the pre-loaded word at 16'h0003.
        drive(1'b0, 1'b1, 16'h0003, 16'h0000);
        smp = cyc;
        snap();
        drive(1'b0, 1'b0, 16'h0003, 16'h0000);
        gap(14);
        for (int k = 0; k < 3; k++) begin
            chk("sweep_latency", k, 64'(r_cyc_a[k] - smp), 64'(lat_of(k) + 2));
            chk("sweep_data", k, 64'(dout_a[k]), 64'h1234);
            chk("sweep_en_count", k, 64'(en_cnt_a[k] - b_en[k]), 64'd1);
        end

        // OE held for 20 cycles: one access, busy until OE has been seen low.
        drive(1'b0, 1'b1, 16'h0040, 16'h0000);
        smp = cyc;
        snap();
        gap(19);
        for (int k = 0; k < 3; k++) chk("held_busy", k, 64'(busy_a[k]), 64'd1);
        @(negedge clk);
        for (int k = 0; k < 3; k++) chk("held_busy_last", k, 64'(busy_a[k]), 64'd1);
        core_oe = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("held_busy_drop", k, 64'(busy_a[k]), 64'd0);
            chk("held_en_count", k, 64'(en_cnt_a[k] - b_en[k]), 64'd1);
            chk("held_r_count", k, 64'(r_cnt_a[k] - b_r[k]), 64'd1);
        end
        gap(3);

        // OE and WE together: write wins, read data register untouched.
        drive(1'b1, 1'b1, 16'h0020, 16'h00AA);
        smp = cyc;
        snap();
        drive(1'b0, 1'b0, 16'h0020, 16'h0000);
        gap(12);
        for (int k = 0; k < 3; k++) begin
            chk("both_latency", k, 64'(r_cyc_a[k] - smp), 64'd2);
            chk("both_we_count", k, 64'(we_cnt_a[k] - b_we[k]), 64'd1);
            chk("both_en_count", k, 64'(en_cnt_a[k] - b_en[k]), 64'd1);
            chk("both_dout_kept", k, 64'(dout_a[k]), 64'(init_val(16'h0040)));
        end

        // Address/data churn during a read of 16'h0005.
        drive(1'b0, 1'b1, 16'h0005, 16'h0000);
        smp = cyc;
        snap();
        for (int i = 0; i < 14; i++) begin
            drive(1'b0, 1'b1, 16'($urandom), 16'($urandom));
            for (int k = 0; k < 3; k++) chk("churn_addr", k, 64'(maddr_a[k]), 64'h0005);
        end
        drive(1'b0, 1'b0, 16'h0000, 16'h0000);
        gap(12);
        for (int k = 0; k < 3; k++) begin
            chk("churn_data", k, 64'(dout_a[k]), 64'(init_val(16'h0005)));
            chk("churn_en_count", k, 64'(en_cnt_a[k] - b_en[k]), 64'd1);
        end

        // Reset while the RD_LAT=7 instance sits in RD_WAIT, then a fresh read.
        drive(1'b0, 1'b1, 16'h0007, 16'h0000);
        smp = cyc;
        gap(4);
        snap();
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) chk("midreset_outputs", k, 64'(obs_a[k]), 64'd0);
        gap(2);
        @(negedge clk);
        for (int k = 0; k < 3; k++) chk("midreset_no_r", k, 64'(r_cnt_a[k] - b_r[k]), 64'd0);
        rst_n = 1'b1;
        smp = cyc;
        gap(12);
        drive(1'b0, 1'b0, 16'h0000, 16'h0000);
        gap(4);
        for (int k = 0; k < 3; k++) begin
            chk("post_reset_latency", k, 64'(r_cyc_a[k] - smp), 64'(lat_of(k) + 2));
            chk("post_reset_data", k, 64'(dout_a[k]), 64'(init_val(16'h0007)));
        end

        // Random request levels over a small address window, rare resets.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            rst_n      = ($urandom_range(0, 199) != 0);
            core_oe    = ($urandom_range(0, 2) == 0);
            core_we    = ($urandom_range(0, 4) == 0);
            core_addr  = 16'($urandom_range(0, 15));
            core_wdata = 16'($urandom);
        end
        @(negedge clk);
        rst_n   = 1'b1;
        core_oe = 1'b0;
        core_we = 1'b0;
        gap(14);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
